// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB command master.
// No logic, so no latency.
// No flow control of its own.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    // Field order matches the flat queue word used by the master: {write, addr, wdata, strb}.
    typedef struct packed {
        logic                        write;
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic [DEF_DATA_WIDTH-1:0]   wdata;
        logic [DEF_DATA_WIDTH/8-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO holding queued commands; head word is visible combinationally.
// A push becomes visible at the head on the cycle after it is written.
// Pushes while full and pops while empty are ignored.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         core_clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Queues commands and issues them as APB transfers in order, one response each.
// Min 4 cycles accept-to-response (queue, SETUP, ACCESS, RESP); wait states add ACCESS cycles.
// cmd_ready low when queue full; FSM holds in RESP until rsp_ready.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH + SW;
    localparam int TW = $clog2(TIMEOUT + 1);

    apb_state_e                     state;
    apb_state_e                     state_n;
    logic                           pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] unused_count;
    logic [CW-1:0]                  head_dat;
    logic [TW-1:0]                  tcnt;
    logic                           timed_out;

    // Gated by PRESET so the queue looks unavailable while reset is held.
    assign cmd_ready = !fifo_full && !PRESET;
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    apb_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (PCLK),
        .rst      (PRESET),
        .push     (cmd_valid && cmd_ready),
        .push_dat ({cmd_write, cmd_addr, cmd_wdata, cmd_strb}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (unused_count)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP:  state_n = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY || timed_out) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = ST_SETUP;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tcnt      <= '0;
        end else begin
            // Loading on the pop edge makes the SETUP cycle carry the command.
            if (pop) begin
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= head_dat[CW-1];
                PADDR   <= head_dat[CW-2 -: ADDR_WIDTH];
                PWDATA  <= head_dat[SW +: DATA_WIDTH];
                PSTRB   <= head_dat[CW-1] ? head_dat[SW-1:0] : '0;
            end
            case (state)
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    tcnt    <= '0;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                    end else if (timed_out) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and randomized checks of apb_cmd_master against an APB slave model and a
// transaction-level reference memory; slave wait states are fixed or random per transfer,
// and one address hangs while another returns PSLVERR.
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam logic [31:0] ERR_ADDR  = 32'hFFFF_FFFC;
    localparam logic [31:0] HANG_ADDR = 32'h0000_0F00;
    localparam logic [31:0] ERR_RDATA = 32'h0BAD_F00D;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .FIFO_DEPTH (4), .TIMEOUT (16)
    ) dut (
        .PCLK (PCLK), .PRESET (PRESET),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE), .PADDR (PADDR),
        .PWDATA (PWDATA), .PSTRB (PSTRB), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h1357_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    // ---------------- APB slave model ----------------
    logic [31:0] smem [64];
    bit          mem_init = 1'b0;
    int          cur_wait = 0;
    int          ws_cnt   = 0;
    int          ws_fixed = 0;
    bit          ws_rand  = 1'b0;
    logic        in_access, is_hang, is_err;

    assign in_access = PSEL && PENABLE;
    assign is_hang   = (PADDR == HANG_ADDR);
    assign is_err    = (PADDR == ERR_ADDR);
    assign PREADY    = in_access && !is_hang && (ws_cnt >= cur_wait);
    assign PRDATA    = (in_access && !PWRITE) ? (is_err ? ERR_RDATA : smem[PADDR[7:2]]) : 32'hDEAD_BEEF;
    // Junk PSLVERR outside ACCESS so a master that samples it at the wrong time is caught.
    assign PSLVERR   = in_access ? (PREADY && is_err) : 1'b1;

    always @(posedge PCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) smem[i] <= init_val(i);
            mem_init <= 1'b1;
        end
        if (PSEL && !PENABLE) cur_wait <= ws_rand ? int'($urandom_range(0, 3)) : ws_fixed;
        if (in_access && !PREADY) ws_cnt <= ws_cnt + 1;
        else                      ws_cnt <= 0;
        if (PREADY && PWRITE && !is_err)
            for (int b = 0; b < 4; b++)
                if (PSTRB[b]) smem[PADDR[7:2]][8*b +: 8] <= PWDATA[8*b +: 8];
    end

    // ---------------- protocol monitor ----------------
    int          proto_bad = 0;
    int          acc_cnt   = 0;
    int          acc_log[$];
    logic        prev_setup = 1'b0, prev_access = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
    logic        prev_write, prev_err;
    logic [31:0] prev_addr, prev_wdata, prev_rdata;
    logic [3:0]  prev_strb;
    logic        m_setup, m_access;

    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_setup = 1'b0; prev_access = 1'b0; prev_rv = 1'b0; acc_cnt = 0;
        end else begin
            m_setup  = PSEL && !PENABLE;
            m_access = PSEL && PENABLE;
            if (PENABLE && !PSEL) proto_bad++;
            if (m_access && !(prev_setup || prev_access)) proto_bad++;
            if (prev_setup && !m_access) proto_bad++;
            if (m_access && prev_access && (PADDR != prev_addr || PWRITE != prev_write ||
                PWDATA != prev_wdata || PSTRB != prev_strb)) proto_bad++;
            if (PSEL && rsp_valid) proto_bad++;
            if (PSEL && !PWRITE && PSTRB != 4'h0) proto_bad++;
            if (prev_rv && !prev_rr && (!rsp_valid || rsp_rdata != prev_rdata || rsp_err != prev_err))
                proto_bad++;
            if (m_access) acc_cnt = prev_access ? acc_cnt + 1 : 1;
            if (prev_access && !m_access) acc_log.push_back(acc_cnt);
            prev_setup = m_setup; prev_access = m_access;
            prev_rv = rsp_valid; prev_rr = rsp_ready;
            prev_rdata = rsp_rdata; prev_err = rsp_err;
            prev_addr = PADDR; prev_write = PWRITE; prev_wdata = PWDATA; prev_strb = PSTRB;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    logic [31:0] rmem  [64];
    logic [31:0] rsave [64];
    exp_t        exp_q[$];

    function automatic void model_accept(input apb_cmd_t c);
        exp_t e;
        int   i;
        i = int'(c.addr[7:2]);
        if (c.addr == HANG_ADDR) begin
            e.rdata = 32'h0; e.err = 1'b1;
        end else if (c.addr == ERR_ADDR) begin
            e.rdata = c.write ? 32'h0 : ERR_RDATA; e.err = 1'b1;
        end else if (c.write) begin
            for (int b = 0; b < 4; b++)
                if (c.strb[b]) rmem[i][8*b +: 8] = c.wdata[8*b +: 8];
            e.rdata = 32'h0; e.err = 1'b0;
        end else begin
            e.rdata = rmem[i]; e.err = 1'b0;
        end
        exp_q.push_back(e);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit       ok;
        apb_cmd_t c;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin ok = 1'b1; break; end
            @(posedge PCLK); #1;
        end
        chk("push_accepted", 32'(ok), 32'd1);
        if (ok) begin
            c.write = w; c.addr = a; c.wdata = d; c.strb = s;
            @(posedge PCLK); #1;
            model_accept(c);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsps(input int n, input bit rnd);
        bit   got;
        int   d;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            d = rnd ? int'($urandom_range(0, 3)) : 0;
            if (d > 0) begin repeat (d) @(posedge PCLK); #1; end
            rsp_ready = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 600; i++) begin
                @(negedge PCLK);
                if (rsp_valid) begin got = 1'b1; break; end
            end
            chk("rsp_seen", 32'(got), 32'd1);
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (got && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            @(posedge PCLK); #1;
            rsp_ready = 1'b0;
            if (!got) break;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          rc;
        logic [31:0] a;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) rmem[i] = init_val(i);

        // Reset values
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 0);       chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);   chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);        chk("rst_pstrb", 32'(PSTRB), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0); chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0); chk("rst_cmd_ready", 32'(cmd_ready), 0);
        @(posedge PCLK); #1; PRESET = 1'b0;
        @(negedge PCLK);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        @(posedge PCLK); #1;

        // Single write, zero wait states
        ws_fixed = 0; acc_log.delete();
        push_cmd(1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
        get_rsps(1, 1'b0);
        chk("wr_access_cycles", acc_log.size() == 1 ? 32'(acc_log[0]) : 32'hFFFF_FFFF, 1);
        chk("slave_mem_0x10", smem[4], 32'hA5A5_0001);

        // Read-back with three wait states
        ws_fixed = 3; acc_log.delete();
        push_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        get_rsps(1, 1'b0);
        chk("rd_access_cycles", acc_log.size() == 1 ? 32'(acc_log[0]) : 32'hFFFF_FFFF, 4);

        // Hung slave hits the timeout
        ws_fixed = 0; acc_log.delete();
        push_cmd(1'b0, HANG_ADDR, 32'h0, 4'h0);
        get_rsps(1, 1'b0);
        chk("timeout_access_cycles", acc_log.size() == 1 ? 32'(acc_log[0]) : 32'hFFFF_FFFF, 16);

        // Slave error, then normal traffic including a partial-strobe write
        push_cmd(1'b1, ERR_ADDR, 32'h1234_5678, 4'hF);
        push_cmd(1'b0, ERR_ADDR, 32'h0, 4'hF);
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        push_cmd(1'b1, 32'h14, 32'hCAFE_BABE, 4'b0101);
        push_cmd(1'b0, 32'h14, 32'h0, 4'hF);
        get_rsps(5, 1'b0);

        // Fill the queue while responses are held off
        push_cmd(1'b1, 32'h18, 32'h1111_2222, 4'hF);
        push_cmd(1'b1, 32'h1C, 32'h3333_4444, 4'hC);
        push_cmd(1'b0, 32'h18, 32'h0, 4'hF);
        push_cmd(1'b1, 32'h20, 32'h5555_6666, 4'h3);
        push_cmd(1'b0, 32'h1C, 32'h0, 4'hF);
        @(negedge PCLK);
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
        rc = 0;
        repeat (8) begin @(negedge PCLK); if (cmd_ready) rc++; end
        @(posedge PCLK); #1; cmd_valid = 1'b0;
        chk("refused_when_full", 32'(rc), 0);
        get_rsps(5, 1'b0);

        // Randomized traffic with random wait states and response backpressure
        ws_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rc = int'($urandom_range(0, 2));
                    if (rc > 0) begin repeat (rc) @(posedge PCLK); #1; end
                    rc = int'($urandom_range(0, 19));
                    a  = (rc == 0) ? ERR_ADDR : (rc == 1) ? HANG_ADDR :
                         {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    push_cmd(1'($urandom), a, $urandom, 4'($urandom));
                end
            end
            get_rsps(40, 1'b1);
        join
        ws_rand = 1'b0;

        // Reset during ACCESS of a queued burst
        ws_fixed = 5;
        rsave = rmem;
        push_cmd(1'b1, 32'h20, 32'hAAAA_0001, 4'hF);
        push_cmd(1'b1, 32'h24, 32'hAAAA_0002, 4'hF);
        push_cmd(1'b1, 32'h28, 32'hAAAA_0003, 4'hF);
        rc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin rc = 1; break; end
        end
        chk("burst_in_access", 32'(rc), 1);
        @(posedge PCLK); #1; PRESET = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("midrst_psel", 32'(PSEL), 0);
        chk("midrst_penable", 32'(PENABLE), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 0);
        @(posedge PCLK); #1; PRESET = 1'b0;
        exp_q.delete();
        rmem = rsave;
        @(negedge PCLK);
        chk("midrst_release_cmd_ready", 32'(cmd_ready), 1);
        rc = 0;
        repeat (10) begin @(negedge PCLK); if (PSEL || rsp_valid) rc++; end
        chk("queue_flushed", 32'(rc), 0);
        @(posedge PCLK); #1;
        ws_fixed = 1;
        push_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        push_cmd(1'b1, 32'h20, 32'h7777_8888, 4'hF);
        push_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        get_rsps(3, 1'b0);

        chk("protocol_violations", 32'(proto_bad), 0);
        chk("leftover_responses", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
